// File: rtl/trigger_capture_block.sv
// trigger_capture_block: logic analyzer front end.
// Synchronizes the probe pins, samples them at a programmable rate, waits for
// a masked trigger condition and then streams samples into the capture FIFO
// until the FIFO reports full. The controller disables/re-arms via syncrst.
module trigger_capture_block #(
    parameter int WIDTH = 3,
    parameter int DIV_W = 16,
    parameter int CNT_W = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             syncrst,
    input  logic [WIDTH-1:0] trig_mask,
    input  logic [1:0]       trig_mode,
    input  logic [DIV_W-1:0] sample_div,
    input  logic [WIDTH-1:0] probe_in,
    input  logic             FIFO_wrfull,
    output logic             FIFO_wrreq,
    output logic [WIDTH-1:0] FIFO_data,
    output logic             triggered,
    output logic [CNT_W-1:0] sample_count,
    output logic [1:0]       state_debug
);

    // State encodings
    localparam logic [1:0] ST_DISABLED = 2'b00;
    localparam logic [1:0] ST_ARMED    = 2'b01;
    localparam logic [1:0] ST_CAPTURE  = 2'b10;
    localparam logic [1:0] ST_DONE     = 2'b11;

    // Trigger mode encodings
    localparam logic [1:0] MODE_RISE   = 2'b00;
    localparam logic [1:0] MODE_FALL   = 2'b01;
    localparam logic [1:0] MODE_CHANGE = 2'b10;
    localparam logic [1:0] MODE_IMM    = 2'b11;

    // Edge/change detector between the previous and current tick samples.
    // Immediate mode is handled by the caller because it ignores the mask.
    function automatic logic trig_hit(
        input logic [1:0]       mode,
        input logic [WIDTH-1:0] s,
        input logic [WIDTH-1:0] p,
        input logic [WIDTH-1:0] mask
    );
        logic hit;
        case (mode)
            MODE_RISE:   hit = |(s & ~p & mask);
            MODE_FALL:   hit = |(~s & p & mask);
            MODE_CHANGE: hit = |((s ^ p) & mask);
            MODE_IMM:    hit = 1'b1;
            default:     hit = 1'b0;
        endcase
        return hit;
    endfunction

    // Counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        logic [CNT_W-1:0] r;
        if (&v) begin
            r = v;
        end else begin
            r = v + {{(CNT_W-1){1'b0}}, 1'b1};
        end
        return r;
    endfunction

    // Flops
    logic [WIDTH-1:0] sync1_q,  sync1_d;
    logic [WIDTH-1:0] sync2_q,  sync2_d;
    logic [1:0]       state_q,  state_d;
    logic [DIV_W-1:0] div_l_q,  div_l_d;
    logic [DIV_W-1:0] pre_cnt_q, pre_cnt_d;
    logic             valid_q,  valid_d;
    logic [WIDTH-1:0] prev_q,   prev_d;
    logic             wrreq_q,  wrreq_d;
    logic [WIDTH-1:0] data_q,   data_d;
    logic             trig_q,   trig_d;
    logic [CNT_W-1:0] count_q,  count_d;

    // Combinational helpers
    logic             tick;
    logic             hit;
    logic [WIDTH-1:0] samp;

    assign samp = sync2_q;

    // Sample tick: prescaler reached the latched divider and we are not disabled.
    always_comb begin
        tick = 1'b0;
        if ((state_q != ST_DISABLED) && (pre_cnt_q == div_l_q)) begin
            tick = 1'b1;
        end else begin
            tick = 1'b0;
        end
    end

    // Trigger decision for the current tick; the first tick after arming only
    // primes the previous-sample register unless the mode is immediate.
    always_comb begin
        hit = 1'b0;
        if (trig_mode == MODE_IMM) begin
            hit = 1'b1;
        end else if (valid_q) begin
            hit = trig_hit(trig_mode, samp, prev_q, trig_mask);
        end else begin
            hit = 1'b0;
        end
    end

    // Two-stage probe synchronizer inputs.
    always_comb begin
        sync1_d = probe_in;
        sync2_d = sync1_q;
    end

    // Prescaler: divider latched while disabled, counter wraps at the divider.
    always_comb begin
        div_l_d   = div_l_q;
        pre_cnt_d = pre_cnt_q;
        if (state_q == ST_DISABLED) begin
            div_l_d = sample_div;
        end else begin
            div_l_d = div_l_q;
        end
        if (syncrst || (state_q == ST_DISABLED)) begin
            pre_cnt_d = {DIV_W{1'b0}};
        end else if (tick) begin
            pre_cnt_d = {DIV_W{1'b0}};
        end else begin
            pre_cnt_d = pre_cnt_q + {{(DIV_W-1){1'b0}}, 1'b1};
        end
    end

    // Main FSM: arming, trigger detection, capture writes and completion.
    always_comb begin
        state_d = state_q;
        valid_d = valid_q;
        prev_d  = prev_q;
        wrreq_d = 1'b0;
        data_d  = data_q;
        trig_d  = trig_q;
        count_d = count_q;
        if (syncrst) begin
            state_d = ST_DISABLED;
            valid_d = 1'b0;
            prev_d  = {WIDTH{1'b0}};
            wrreq_d = 1'b0;
            data_d  = {WIDTH{1'b0}};
            trig_d  = 1'b0;
            count_d = {CNT_W{1'b0}};
        end else begin
            case (state_q)
                ST_DISABLED: begin
                    state_d = ST_ARMED;
                    valid_d = 1'b0;
                end
                ST_ARMED: begin
                    if (tick) begin
                        prev_d  = samp;
                        valid_d = 1'b1;
                        if (hit) begin
                            state_d = ST_CAPTURE;
                            trig_d  = 1'b1;
                            // The trigger sample itself is the first capture.
                            if (!FIFO_wrfull) begin
                                wrreq_d = 1'b1;
                                data_d  = samp;
                                count_d = sat_inc(count_q);
                            end else begin
                                wrreq_d = 1'b0;
                            end
                        end else begin
                            state_d = ST_ARMED;
                        end
                    end else begin
                        state_d = ST_ARMED;
                    end
                end
                ST_CAPTURE: begin
                    // Full wins over a coincident tick: no write, finish.
                    if (FIFO_wrfull) begin
                        state_d = ST_DONE;
                    end else if (tick) begin
                        wrreq_d = 1'b1;
                        data_d  = samp;
                        count_d = sat_inc(count_q);
                    end else begin
                        wrreq_d = 1'b0;
                    end
                end
                ST_DONE: begin
                    state_d = ST_DONE;
                end
                default: begin
                    state_d = ST_DISABLED;
                end
            endcase
        end
    end

    // State and datapath registers with asynchronous active-low clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q   <= {WIDTH{1'b0}};
            sync2_q   <= {WIDTH{1'b0}};
            state_q   <= ST_DISABLED;
            div_l_q   <= {DIV_W{1'b0}};
            pre_cnt_q <= {DIV_W{1'b0}};
            valid_q   <= 1'b0;
            prev_q    <= {WIDTH{1'b0}};
            wrreq_q   <= 1'b0;
            data_q    <= {WIDTH{1'b0}};
            trig_q    <= 1'b0;
            count_q   <= {CNT_W{1'b0}};
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            state_q   <= state_d;
            div_l_q   <= div_l_d;
            pre_cnt_q <= pre_cnt_d;
            valid_q   <= valid_d;
            prev_q    <= prev_d;
            wrreq_q   <= wrreq_d;
            data_q    <= data_d;
            trig_q    <= trig_d;
            count_q   <= count_d;
        end
    end

    assign FIFO_wrreq   = wrreq_q;
    assign FIFO_data    = data_q;
    assign triggered    = trig_q;
    assign sample_count = count_q;
    assign state_debug  = state_q;

endmodule

// File: tb/tb_trigger_capture_block.sv
// Directed, table-driven bench for trigger_capture_block.
module tb_trigger_capture_block;

    logic        clk;
    logic        rst;
    logic        syncrst;
    logic [2:0]  trig_mask;
    logic [1:0]  trig_mode;
    logic [15:0] sample_div;
    logic [2:0]  probe_in;
    logic        FIFO_wrfull;
    logic        FIFO_wrreq;
    logic [2:0]  FIFO_data;
    logic        triggered;
    logic [11:0] sample_count;
    logic [1:0]  state_debug;

    int n_cmp  = 0;
    int n_fail = 0;

    trigger_capture_block #(.WIDTH(3), .DIV_W(16), .CNT_W(12)) dut (
        .clk          (clk),
        .rst          (rst),
        .syncrst      (syncrst),
        .trig_mask    (trig_mask),
        .trig_mode    (trig_mode),
        .sample_div   (sample_div),
        .probe_in     (probe_in),
        .FIFO_wrfull  (FIFO_wrfull),
        .FIFO_wrreq   (FIFO_wrreq),
        .FIFO_data    (FIFO_data),
        .triggered    (triggered),
        .sample_count (sample_count),
        .state_debug  (state_debug)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] mode;
        logic [2:0] mask;
        logic [2:0] p_val;
        logic [2:0] s_val;
        logic       exp_trig;
        logic [2:0] exp_data;
    } vec_t;

    vec_t vecs [12];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Disable, settle probe at p_val, arm, switch probe to s_val, observe.
    task automatic run_vec(input int idx);
        vec_t       v;
        logic       seen;
        logic [2:0] first;
        v = vecs[idx];
        syncrst = 1'b1; FIFO_wrfull = 1'b0;
        trig_mode = v.mode; trig_mask = v.mask; sample_div = 16'd0; probe_in = v.p_val;
        repeat (4) step();
        syncrst = 1'b0;
        seen = 1'b0; first = 3'b000;
        for (int c = 0; c < 12; c++) begin
            if (c == 5) probe_in = v.s_val;
            step();
            if (FIFO_wrreq && !seen) begin
                seen  = 1'b1;
                first = FIFO_data;
            end
        end
        chk($sformatf("vec%0d triggered", idx), {31'd0, triggered}, {31'd0, v.exp_trig});
        chk($sformatf("vec%0d state", idx), {30'd0, state_debug}, v.exp_trig ? 32'd2 : 32'd1);
        chk($sformatf("vec%0d wrote", idx), {31'd0, seen}, {31'd0, v.exp_trig});
        if (v.exp_trig) chk($sformatf("vec%0d data", idx), {29'd0, first}, {29'd0, v.exp_data});
    endtask

    initial begin
        int pulses;
        int last_cyc;
        int extra;
        logic found;

        vecs[0]  = '{2'b00, 3'b010, 3'b000, 3'b010, 1'b1, 3'b010};
        vecs[1]  = '{2'b00, 3'b010, 3'b000, 3'b001, 1'b0, 3'b000};
        vecs[2]  = '{2'b00, 3'b111, 3'b011, 3'b111, 1'b1, 3'b111};
        vecs[3]  = '{2'b00, 3'b011, 3'b011, 3'b001, 1'b0, 3'b000};
        vecs[4]  = '{2'b01, 3'b100, 3'b100, 3'b000, 1'b1, 3'b000};
        vecs[5]  = '{2'b01, 3'b001, 3'b000, 3'b001, 1'b0, 3'b000};
        vecs[6]  = '{2'b10, 3'b101, 3'b010, 3'b011, 1'b1, 3'b011};
        vecs[7]  = '{2'b10, 3'b010, 3'b000, 3'b101, 1'b0, 3'b000};
        vecs[8]  = '{2'b10, 3'b000, 3'b000, 3'b111, 1'b0, 3'b000};
        vecs[9]  = '{2'b00, 3'b000, 3'b000, 3'b111, 1'b0, 3'b000};
        vecs[10] = '{2'b11, 3'b000, 3'b101, 3'b010, 1'b1, 3'b101};
        vecs[11] = '{2'b01, 3'b111, 3'b111, 3'b000, 1'b1, 3'b000};

        // Reset state
        rst = 1'b0; syncrst = 1'b1; trig_mask = 3'b000; trig_mode = 2'b00;
        sample_div = 16'd0; probe_in = 3'b000; FIFO_wrfull = 1'b0;
        repeat (3) step();
        chk("rst wrreq", {31'd0, FIFO_wrreq}, 32'd0);
        chk("rst state", {30'd0, state_debug}, 32'd0);
        rst = 1'b1;
        repeat (3) step();
        chk("disabled state", {30'd0, state_debug}, 32'd0);
        chk("disabled trig", {31'd0, triggered}, 32'd0);
        chk("disabled count", {20'd0, sample_count}, 32'd0);
        chk("disabled data", {29'd0, FIFO_data}, 32'd0);
        syncrst = 1'b0;
        step();
        chk("armed state", {30'd0, state_debug}, 32'd1);

        // Rising-edge latency, with a non-matching edge first
        syncrst = 1'b1; trig_mode = 2'b00; trig_mask = 3'b010; sample_div = 16'd0; probe_in = 3'b000;
        repeat (4) step();
        syncrst = 1'b0;
        repeat (4) step();
        probe_in = 3'b001;
        found = 1'b0;
        repeat (6) begin step(); if (FIFO_wrreq) found = 1'b1; end
        chk("bit0 edge no trig", {31'd0, triggered | found}, 32'd0);
        probe_in = 3'b000;
        repeat (5) step();
        probe_in = 3'b010;
        step(); chk("lat wrreq c1", {31'd0, FIFO_wrreq}, 32'd0);
        step(); chk("lat wrreq c2", {31'd0, FIFO_wrreq}, 32'd0);
        step(); chk("lat wrreq c3", {31'd0, FIFO_wrreq}, 32'd1);
        chk("lat data", {29'd0, FIFO_data}, 32'd2);
        chk("lat triggered", {31'd0, triggered}, 32'd1);
        chk("lat count", {20'd0, sample_count}, 32'd1);

        // Trigger condition table
        for (int i = 0; i < 12; i++) run_vec(i);

        // Divider: one write every 4 clocks, stop on full after 8
        syncrst = 1'b1; trig_mode = 2'b11; trig_mask = 3'b000; sample_div = 16'd3;
        FIFO_wrfull = 1'b0; probe_in = 3'b110;
        repeat (4) step();
        syncrst = 1'b0;
        pulses = 0; last_cyc = 0;
        for (int c = 0; c < 60 && pulses < 8; c++) begin
            step();
            if (FIFO_wrreq) begin
                pulses++;
                if (pulses > 1) chk($sformatf("div interval %0d", pulses), c - last_cyc, 32'd4);
                last_cyc = c;
            end
        end
        chk("div pulses seen", pulses, 32'd8);
        chk("div count at 8", {20'd0, sample_count}, 32'd8);
        FIFO_wrfull = 1'b1;
        extra = 0;
        repeat (12) begin step(); if (FIFO_wrreq) extra++; end
        chk("div no extra wr", extra, 32'd0);
        chk("div count held", {20'd0, sample_count}, 32'd8);
        chk("div done state", {30'd0, state_debug}, 32'd3);
        chk("div trig held", {31'd0, triggered}, 32'd1);

        // Full coinciding with a tick: no write, DONE next cycle
        syncrst = 1'b1; FIFO_wrfull = 1'b0; sample_div = 16'd3; probe_in = 3'b100;
        repeat (4) step();
        syncrst = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 20 && !found; c++) begin
            step();
            if (FIFO_wrreq) found = 1'b1;
        end
        chk("coll first write", {31'd0, found}, 32'd1);
        repeat (3) step();
        FIFO_wrfull = 1'b1;
        step();
        chk("coll no write", {31'd0, FIFO_wrreq}, 32'd0);
        chk("coll done", {30'd0, state_debug}, 32'd3);
        chk("coll count", {20'd0, sample_count}, 32'd1);

        // Re-arm from DONE and capture a falling edge
        syncrst = 1'b1;
        step();
        syncrst = 1'b0; FIFO_wrfull = 1'b0; trig_mode = 2'b01; trig_mask = 3'b100; sample_div = 16'd0;
        chk("rearm disabled", {30'd0, state_debug}, 32'd0);
        chk("rearm trig clr", {31'd0, triggered}, 32'd0);
        chk("rearm count clr", {20'd0, sample_count}, 32'd0);
        step();
        chk("rearm armed", {30'd0, state_debug}, 32'd1);
        repeat (3) step();
        probe_in = 3'b000;
        found = 1'b0;
        for (int c = 0; c < 8 && !found; c++) begin
            step();
            if (FIFO_wrreq) found = 1'b1;
        end
        chk("rearm wrote", {31'd0, found}, 32'd1);
        chk("rearm data", {29'd0, FIFO_data}, 32'd0);
        chk("rearm triggered", {31'd0, triggered}, 32'd1);

        // Asynchronous reset in the middle of a write
        step();
        chk("async pre wrreq", {31'd0, FIFO_wrreq}, 32'd1);
        #2 rst = 1'b0;
        #1;
        chk("async wrreq", {31'd0, FIFO_wrreq}, 32'd0);
        chk("async state", {30'd0, state_debug}, 32'd0);
        chk("async trig", {31'd0, triggered}, 32'd0);
        chk("async count", {20'd0, sample_count}, 32'd0);
        step();
        rst = 1'b1;
        repeat (2) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
